// File: rtl/regfile_pkg.sv
// Shared register-file constants, virtual read-only register indices and arbiter state type.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 16;

  // r14 reads back the PC and r15 reads the IO port; neither holds stored data.
  localparam logic [ADDR_W-1:0] PC_REG = 4'hE;
  localparam logic [ADDR_W-1:0] IO_REG = 4'hF;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_FORCE
  } arb_state_e;

  function automatic logic is_ro_addr(input logic [ADDR_W-1:0] addr);
    return (addr == PC_REG) || (addr == IO_REG);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback, IO-loader and register-file write-port signals around the arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned ADDRESSWIDTH = 4
);

  logic                    wb_we;
  logic [ADDRESSWIDTH-1:0] wb_wa;
  logic [WIDTH-1:0]        wb_wd;

  logic                    io_valid;
  logic [ADDRESSWIDTH-1:0] io_addr;
  logic [WIDTH-1:0]        io_data;
  logic                    io_ready;

  logic                    stall_wb;

  logic                    we3;
  logic [ADDRESSWIDTH-1:0] wa3;
  logic [WIDTH-1:0]        wd3;

  logic                    bad_write;
  logic                    bad_write_sticky;

  // Arbiter side.
  modport slave (
    input  wb_we, wb_wa, wb_wd, io_valid, io_addr, io_data,
    output io_ready, stall_wb, we3, wa3, wd3, bad_write, bad_write_sticky
  );

  // Pipeline / loader / register-file side.
  modport master (
    output wb_we, wb_wa, wb_wd, io_valid, io_addr, io_data,
    input  io_ready, stall_wb, we3, wa3, wd3, bad_write, bad_write_sticky
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between writeback (priority) and the IO loader,
// with a starvation-forced stall cycle and dropping of writes to read-only r14/r15.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned ADDRESSWIDTH = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                   clk,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned CntW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STARVE_LIMIT - 1);

  arb_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_bad, r_sticky;

  logic                    w_wb_grant, w_io_grant, w_grant, w_ro, w_bad;
  logic [ADDRESSWIDTH-1:0] w_addr;
  logic [WIDTH-1:0]        w_data;

  always_comb begin
    w_wb_grant   = 1'b0;
    bus.io_ready = 1'b0;
    if (!reset) begin
      if (r_state == ARB_FORCE) begin
        bus.io_ready = 1'b1;
      end else if (bus.wb_we) begin
        w_wb_grant = 1'b1;
      end else begin
        bus.io_ready = 1'b1;
      end
    end
    w_io_grant = bus.io_ready & bus.io_valid;
    w_grant    = w_wb_grant | w_io_grant;
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    if (w_wb_grant) begin
      w_addr = bus.wb_wa;
      w_data = bus.wb_wd;
    end else if (w_io_grant) begin
      w_addr = bus.io_addr;
      w_data = bus.io_data;
    end
    w_ro = is_ro_addr(ADDR_W'(w_addr));
    w_bad = w_grant & w_ro;
  end

  assign bus.we3              = w_grant & ~w_ro;
  assign bus.wa3              = w_addr;
  assign bus.wd3              = w_data;
  assign bus.stall_wb         = (r_state == ARB_FORCE);
  assign bus.bad_write        = r_bad;
  assign bus.bad_write_sticky = r_sticky;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = '0;
    unique case (r_state)
      ARB_IDLE: begin
        // Only a request left waiting this cycle counts towards starvation.
        if (bus.io_valid && !bus.io_ready) begin
          if (r_cnt == CntLast) begin
            w_state_d = ARB_FORCE;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      ARB_FORCE: w_state_d = ARB_IDLE;
      default:   w_state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_cnt    <= '0;
      r_bad    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_bad    <= w_bad;
      r_sticky <= r_sticky | w_bad;
    end
  end

endmodule
